// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: FSM states, opcodes and
// instruction field offsets (offsets above the WIDTH-bit immediate).
package alu_seq_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_WB    = 2'd3
   } state_t;

   localparam logic [7:0] OP_ADD  = 8'h07;
   localparam logic [7:0] OP_SUB  = 8'h08;
   localparam logic [7:0] OP_ST   = 8'h1D;
   localparam logic [7:0] OP_STN  = 8'h1E;
   localparam logic [7:0] OP_JMP  = 8'h21;
   localparam logic [7:0] OP_JMPC = 8'h22;
   localparam logic [7:0] OP_END  = 8'h3F;

   // Instruction word is {op, src1[1:0], src2[1:0], imm}; offsets relative to WIDTH
   localparam int SRC2_OFS = 0;
   localparam int SRC1_OFS = 2;
   localparam int OP_OFS   = 4;

endpackage

// File: rtl/alu_sequencer.sv
// Fetch/execute/writeback sequencer driving an external ALU from an instruction
// memory; keeps the accumulator, program counter and registered carry/borrow.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int IWIDTH   = 8,
   parameter int PC_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   output logic                      imem_req,
   output logic [PC_WIDTH-1:0]       imem_addr,
   input  logic                      imem_valid,
   input  logic [IWIDTH+4+WIDTH-1:0] imem_data,
   output logic [IWIDTH-1:0]         alu_op_code,
   output logic [1:0]                alu_src1_choice,
   output logic [1:0]                alu_src2_choice,
   output logic [WIDTH-1:0]          alu_imm,
   output logic                      alu_c_in,
   output logic                      alu_b_in,
   input  logic [WIDTH-1:0]          alu_out,
   input  logic                      alu_c_out,
   input  logic                      alu_b_out,
   input  logic                      alu_flag_valid,
   output logic [WIDTH-1:0]          acc,
   output logic                      st_we,
   output logic [WIDTH-1:0]          st_data,
   output logic                      busy,
   output logic                      done
);

   localparam int IW = IWIDTH + 4 + WIDTH;

   state_t              state, state_nx;
   logic [PC_WIDTH-1:0] pc;
   logic [WIDTH-1:0]    acc_q;
   logic [WIDTH-1:0]    result_q;
   logic [IW-1:0]       instr_q;
   logic                carry_q;
   logic                borrow_q;
   logic                done_q;

   logic [IWIDTH-1:0]   op;
   logic [WIDTH-1:0]    imm;
   logic                is_store, is_jmp, is_jmpc, is_end;
   logic [PC_WIDTH-1:0] jump_target;

   assign op          = instr_q[WIDTH+OP_OFS +: IWIDTH];
   assign imm         = instr_q[WIDTH-1:0];
   assign is_store    = (op == IWIDTH'(OP_ST)) || (op == IWIDTH'(OP_STN));
   assign is_jmp      = (op == IWIDTH'(OP_JMP));
   assign is_jmpc     = (op == IWIDTH'(OP_JMPC));
   assign is_end      = (op == IWIDTH'(OP_END));
   assign jump_target = PC_WIDTH'(imm);

   assign imem_addr       = pc;
   assign alu_op_code     = op;
   assign alu_src1_choice = instr_q[WIDTH+SRC1_OFS +: 2];
   assign alu_src2_choice = instr_q[WIDTH+SRC2_OFS +: 2];
   assign alu_imm         = imm;
   assign alu_c_in        = carry_q;
   assign alu_b_in        = borrow_q;
   assign acc             = acc_q;
   assign st_data         = st_we ? result_q : '0;
   assign busy            = (state != S_IDLE);
   assign done            = done_q;

   always_comb begin
      state_nx = state;
      imem_req = 1'b0;
      st_we    = 1'b0;
      case (state)
         S_IDLE:  if (start) state_nx = S_FETCH;
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_valid) state_nx = S_EXEC;
         end
         S_EXEC: begin
            if (is_end)                 state_nx = S_IDLE;
            else if (is_jmp || is_jmpc) state_nx = S_FETCH;
            else                        state_nx = S_WB;
         end
         S_WB: begin
            st_we    = is_store;
            state_nx = S_FETCH;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         pc       <= '0;
         acc_q    <= '0;
         result_q <= '0;
         instr_q  <= '0;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state  <= state_nx;
         done_q <= (state == S_EXEC) && is_end;
         case (state)
            S_IDLE: if (start) begin
               pc       <= '0;
               carry_q  <= 1'b0;
               borrow_q <= 1'b0;
            end
            S_FETCH: if (imem_valid) instr_q <= imem_data;
            S_EXEC: begin
               // Control-flow ops leave the result and flags untouched
               if (is_jmp) begin
                  pc <= jump_target;
               end else if (is_jmpc) begin
                  pc <= acc_q[0] ? jump_target : pc + 1'b1;
               end else if (!is_end) begin
                  result_q <= alu_out;
                  if (alu_flag_valid) begin
                     carry_q  <= alu_c_out;
                     borrow_q <= alu_b_out;
                  end
               end
            end
            S_WB: begin
               if (!is_store) acc_q <= result_q;
               pc <= pc + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
